// File: rtl/stream_accumulator_pkg.sv
// Shared types for the stream accumulator: FSM state and sample count.
// Used by stream_accumulator and sat_add.
package stream_accumulator_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_e;

  typedef logic [15:0] cnt_t;

  localparam cnt_t CNT_ONE = 16'd1;

endpackage

// File: rtl/sat_add.sv
// Signed adder of width W. Saturates when ACC_SATURATE_EN is defined,
// otherwise wraps. Ports: i_a, i_b addends; o_sum result; o_sat clamp flag.
module sat_add
  import stream_accumulator_pkg::*;
#(
  parameter int W = 36
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_sum,
  output logic         o_sat
);

  logic [W-1:0] w_raw;

  assign w_raw = i_a + i_b;

`ifdef ACC_SATURATE_EN
  logic w_ovf;

  // Overflow only when both operands share a sign the result lost.
  assign w_ovf = (i_a[W-1] == i_b[W-1]) &&
                 (w_raw[W-1] != i_a[W-1]);

  always_comb begin
    o_sum = w_raw;
    o_sat = w_ovf;
    if (w_ovf) begin
      o_sum = i_a[W-1] ? {1'b1, {(W-1){1'b0}}}
                       : {1'b0, {(W-1){1'b1}}};
    end
  end
`else
  assign o_sum = w_raw;
  assign o_sat = 1'b0;
`endif

endmodule

// File: rtl/stream_accumulator.sv
// Sums signed sample vectors (VEC_LEN samples or up to in_last) and
// presents each sum with its sample count and a sticky saturation flag.
// Ports: clk, rst (async, active-high); in_valid/in_ready/in_data/in_last
// sample stream; out_valid/out_ready/out_data/out_count/out_sat results.
// Build option: ACC_SATURATE_EN selects clamping instead of wrapping.
module stream_accumulator
  import stream_accumulator_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ACC_WIDTH  = 36,
  parameter int VEC_LEN    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [15:0]           out_count,
  output logic                  out_sat
);

  localparam cnt_t VEC_MAX = cnt_t'(VEC_LEN);

  state_e               r_state;
  state_e               w_state_nx;
  logic [ACC_WIDTH-1:0] r_acc;
  cnt_t                 r_cnt;
  logic                 r_sat;
  logic [ACC_WIDTH-1:0] r_out_data;
  cnt_t                 r_out_count;
  logic                 r_out_sat;

  logic                 w_in_fire;
  logic                 w_out_fire;
  logic                 w_first;
  logic                 w_done;
  logic [ACC_WIDTH-1:0] w_ext;
  logic [ACC_WIDTH-1:0] w_add_a;
  logic [ACC_WIDTH-1:0] w_sum;
  logic                 w_sat;
  logic                 w_sat_nx;
  cnt_t                 w_cnt_nx;

  // Holding a result only blocks input when downstream also stalls.
  assign in_ready   = (r_state == ACCUM) | out_ready;
  assign out_valid  = (r_state == HOLD);
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = out_valid & out_ready;

  // An empty accumulator (cnt 0) means this sample opens a vector.
  assign w_first  = (r_cnt == '0);
  assign w_ext    = ACC_WIDTH'($signed(in_data));
  assign w_add_a  = w_first ? '0 : r_acc;
  assign w_cnt_nx = w_first ? CNT_ONE : r_cnt + CNT_ONE;
  assign w_sat_nx = (r_sat & ~w_first) | w_sat;
  assign w_done   = w_in_fire &
                    ((w_cnt_nx == VEC_MAX) | in_last);

  sat_add #(
    .W(ACC_WIDTH)
  ) u_sat_add (
    .i_a  (w_add_a),
    .i_b  (w_ext),
    .o_sum(w_sum),
    .o_sat(w_sat)
  );

  always_comb begin
    w_state_nx = r_state;
    unique case (r_state)
      ACCUM: begin
        if (w_done) w_state_nx = HOLD;
      end
      HOLD: begin
        if (w_out_fire) w_state_nx = w_done ? HOLD : ACCUM;
      end
      default: w_state_nx = ACCUM;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ACCUM;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_sat       <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
      r_out_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (w_done) begin
        r_acc       <= '0;
        r_cnt       <= '0;
        r_sat       <= 1'b0;
        r_out_data  <= w_sum;
        r_out_count <= w_cnt_nx;
        r_out_sat   <= w_sat_nx;
      end else if (w_in_fire) begin
        r_acc <= w_sum;
        r_cnt <= w_cnt_nx;
        r_sat <= w_sat_nx;
      end
    end
  end

  assign out_data  = r_out_data;
  assign out_count = r_out_count;
  assign out_sat   = r_out_sat;

endmodule

// File: tb/tb_stream_accumulator.sv
// Directed bench for stream_accumulator with a result scoreboard.
// Honours ACC_SATURATE_EN when computing expected sums.
module tb_stream_accumulator;

  localparam int DW = 8;
  localparam int AW = 9;
  localparam int VL = 4;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_data;
  logic [15:0]   out_count;
  logic          out_sat;

  stream_accumulator #(
    .DATA_WIDTH(DW),
    .ACC_WIDTH (AW),
    .VEC_LEN   (VL)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_count(out_count),
    .out_sat  (out_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] d;
    logic [15:0]   c;
    logic          s;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   n_out  = 0;
  int   m_acc  = 0;
  int   m_cnt  = 0;
  logic m_sat  = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_sat = 1'b0;
  endtask

  task automatic model_accept(input int d, input logic last);
    int s;
    logic [AW-1:0] t;
    exp_t e;
    if (m_cnt == 0) begin
      s = d;
      m_sat = 1'b0;
    end else begin
      s = m_acc + d;
`ifdef ACC_SATURATE_EN
      if (s > 255) begin
        s = 255;
        m_sat = 1'b1;
      end
      if (s < -256) begin
        s = -256;
        m_sat = 1'b1;
      end
`else
      t = s[AW-1:0];
      s = int'($signed(t));
`endif
    end
    m_acc = s;
    m_cnt++;
    if (m_cnt == VL || last) begin
      e.d = m_acc[AW-1:0];
      e.c = m_cnt[15:0];
      e.s = m_sat;
      q.push_back(e);
      model_reset();
    end
  endtask

  // Drives one sample and returns after the accepting edge (+1).
  task automatic send(input int d, input logic last, output int waits);
    logic got;
    got = 1'b0;
    waits = 0;
    in_valid = 1'b1;
    in_data  = d[DW-1:0];
    in_last  = last;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
      waits++;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    else model_accept(d, last);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      n_out++;
      if (q.size() == 0) begin
        chk("unexpected_out", 64'd1, 64'd0);
      end else begin
        e = q.pop_front();
        chk("out_data", 64'(out_data), 64'(e.d));
        chk("out_count", 64'(out_count), 64'(e.c));
        chk("out_sat", 64'(out_sat), 64'(e.s));
      end
    end
  end

  initial begin : stim
    int w;
    int n0;
    clk = 1'b0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b1;
    #12;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_count", 64'(out_count), 64'd0);
    chk("rst_out_sat", 64'(out_sat), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk);
    #1 rst = 1'b0;

    // 1,2,3,4 -> 10 with latency 1
    send(1, 1'b0, w);
    send(2, 1'b0, w);
    send(3, 1'b0, w);
    chk("lat_pre", 64'(out_valid), 64'd0);
    send(4, 1'b0, w);
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data", 64'(out_data), 64'd10);
    idle(1);
    chk("lat_drop", 64'(out_valid), 64'd0);

    // early close: 5,-7 -> -2, count 2
    send(5, 1'b0, w);
    send(-7, 1'b1, w);
    chk("last_data", 64'(out_data), 64'h1FE);
    idle(2);

    // downstream stall in HOLD
    out_ready = 1'b0;
    send(1, 1'b0, w);
    send(2, 1'b0, w);
    send(3, 1'b0, w);
    send(4, 1'b0, w);
    in_valid = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("stall_in_ready", 64'(in_ready), 64'd0);
      chk("stall_valid", 64'(out_valid), 64'd1);
      chk("stall_data", 64'(out_data), 64'd10);
      chk("stall_count", 64'(out_count), 64'd4);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    send(9, 1'b0, w);
    chk("resume_wait", 64'(w), 64'd0);
    send(1, 1'b1, w);
    chk("resume_data", 64'(out_data), 64'd10);
    chk("resume_count", 64'(out_count), 64'd2);
    idle(2);

    // one-sample vector accepted while a result drains
    out_ready = 1'b0;
    send(1, 1'b0, w);
    send(1, 1'b0, w);
    send(1, 1'b0, w);
    send(1, 1'b0, w);
    idle(1);
    out_ready = 1'b1;
    send(7, 1'b1, w);
    chk("one_valid", 64'(out_valid), 64'd1);
    chk("one_count", 64'(out_count), 64'd1);
    idle(2);

    // saturation / wrap, both directions
    repeat (4) send(127, 1'b0, w);
    repeat (4) send(-128, 1'b0, w);
    idle(3);

    // reset mid-vector
    send(3, 1'b0, w);
    send(3, 1'b0, w);
    idle(0);
    rst = 1'b1;
    #1;
    chk("rstmid_valid", 64'(out_valid), 64'd0);
    chk("rstmid_ready", 64'(in_ready), 64'd1);
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) send(1, 1'b0, w);
    chk("post_rst_data", 64'(out_data), 64'd4);
    idle(2);

    // reset while holding a result
    out_ready = 1'b0;
    repeat (4) send(2, 1'b0, w);
    idle(1);
    chk("hold_valid", 64'(out_valid), 64'd1);
    rst = 1'b1;
    #1;
    chk("rsthold_valid", 64'(out_valid), 64'd0);
    chk("rsthold_data", 64'(out_data), 64'd0);
    chk("rsthold_count", 64'(out_count), 64'd0);
    chk("rsthold_ready", 64'(in_ready), 64'd1);
    q.delete();
    model_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    out_ready = 1'b1;

    // continuous stream of 32 samples
    n0 = n_out;
    for (int i = 0; i < 32; i++) begin
      send(((i * 37) % 256) - 128, 1'b0, w);
      chk("stream_no_bubble", 64'(w), 64'd0);
    end
    idle(3);
    chk("stream_results", 64'(n_out - n0), 64'd8);
    chk("queue_empty", 64'(q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
